// File: rtl/led_scan_ctrl.sv
// Double-buffered LED frame scanner: UART bytes fill the write bank while the display
// bank is shifted out row by row (SHIFT -> LATCH -> SHOW), banks swapping at frame end.
module led_scan_ctrl #(
    parameter int ROWS       = 8,
    parameter int COLS       = 32,
    parameter int CLK_DIV    = 4,
    parameter int ON_CYCLES  = 1000,
    parameter int GAP_CYCLES = 50000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    DO,
    output logic                    CLKimpr,
    output logic                    LAT,
    output logic                    STB,
    output logic [$clog2(ROWS)-1:0] ROW,
    output logic                    frame_done
);

    localparam int BPR     = COLS / 8;
    localparam int NBYTES  = ROWS * BPR;
    localparam int RW      = $clog2(ROWS);
    localparam int PW      = $clog2(NBYTES);
    localparam int BW      = $clog2(COLS);
    localparam int CNT_MAX = (2 * CLK_DIV > ON_CYCLES) ? 2 * CLK_DIV : ON_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int GW      = $clog2(GAP_CYCLES + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] HALF      = CW'(CLK_DIV);
    localparam logic [CW-1:0] LAT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SHOW_LAST = CW'(ON_CYCLES - 1);
    localparam logic [BW-1:0] COL_LAST  = BW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(NBYTES - 1);
    localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_CYCLES);

    typedef enum logic [1:0] {SHIFT, LATCH, SHOW} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            phase_end;
    logic [BW-1:0]   bit_cnt;
    logic [RW-1:0]   scan_row;
    logic [PW-1:0]   wr_ptr, wr_idx, rd_addr;
    logic [GW-1:0]   gap_cnt;
    logic            gap_hit, frame_last, swap_now;
    logic            swap_pending, disp_bank, disp_valid;
    logic [7:0]      rd_byte;
    logic [7:0]      mem [2][NBYTES];

    // A byte arriving once the gap has expired is always byte 0 of a new frame.
    assign gap_hit    = (gap_cnt == GAP_MAX);
    assign wr_idx     = gap_hit ? '0 : wr_ptr;
    assign frame_last = rx_valid && (wr_idx == PTR_LAST);
    assign swap_now   = (state == SHOW) && phase_end && (scan_row == ROW_LAST) && swap_pending;

    always_ff @(posedge CLK) begin
        if (rx_valid && !RST)
            mem[~disp_bank][wr_idx] <= rx_data;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr       <= '0;
            gap_cnt      <= '0;
            frame_done   <= 1'b0;
            swap_pending <= 1'b0;
            disp_bank    <= 1'b0;
            disp_valid   <= 1'b0;
        end else begin
            frame_done <= frame_last;
            if (rx_valid) begin
                gap_cnt <= '0;
                wr_ptr  <= frame_last ? '0 : wr_idx + PW'(1);
            end else begin
                if (!gap_hit) gap_cnt <= gap_cnt + GW'(1);
                if (gap_hit)  wr_ptr  <= '0;
            end
            if (swap_now) begin
                disp_bank    <= ~disp_bank;
                disp_valid   <= 1'b1;
                swap_pending <= 1'b0;
            end
            // A completion coinciding with the swap arms the next boundary.
            if (frame_last) swap_pending <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= SHIFT;
            cnt      <= '0;
            bit_cnt  <= '0;
            scan_row <= '0;
            ROW      <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= phase_end ? '0 : cnt + CW'(1);
            if (state == SHIFT && phase_end)
                bit_cnt <= (bit_cnt == COL_LAST) ? '0 : bit_cnt + BW'(1);
            if (state == SHIFT && phase_end && bit_cnt == COL_LAST)
                ROW <= scan_row;
            if (state == SHOW && phase_end)
                scan_row <= (scan_row == ROW_LAST) ? '0 : scan_row + RW'(1);
        end
    end

    always_comb begin
        phase_end = 1'b0;
        state_nxt = state;
        case (state)
            SHIFT: begin
                phase_end = (cnt == BIT_LAST);
                if (phase_end && bit_cnt == COL_LAST) state_nxt = LATCH;
            end
            LATCH: begin
                phase_end = (cnt == LAT_LAST);
                if (phase_end) state_nxt = SHOW;
            end
            SHOW: begin
                phase_end = (cnt == SHOW_LAST);
                if (phase_end) state_nxt = SHIFT;
            end
            default: state_nxt = SHIFT;
        endcase
    end

    assign rd_addr = PW'(int'(scan_row) * BPR + int'(bit_cnt >> 3));
    assign rd_byte = mem[disp_bank][rd_addr];

    always_comb begin
        DO      = 1'b0;
        CLKimpr = 1'b0;
        LAT     = 1'b0;
        STB     = 1'b0;
        case (state)
            SHIFT: begin
                DO      = disp_valid && rd_byte[3'd7 - bit_cnt[2:0]];
                CLKimpr = (cnt >= HALF);
            end
            LATCH:   LAT = 1'b1;
            SHOW:    STB = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl (ROWS=2, COLS=8, CLK_DIV=2, ON_CYCLES=10, GAP_CYCLES=100):
// a negedge monitor reconstructs latched rows and pulse widths from the chain outputs.
module tb_led_scan_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       DO, CLKimpr, LAT, STB, frame_done;
    logic [0:0] ROW;

    led_scan_ctrl #(
        .ROWS(2), .COLS(8), .CLK_DIV(2), .ON_CYCLES(10), .GAP_CYCLES(100)
    ) dut (
        .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
        .DO(DO), .CLKimpr(CLKimpr), .LAT(LAT), .STB(STB), .ROW(ROW),
        .frame_done(frame_done)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    int cyc = 0, lat_count = 0, rises = 0, last_rises = 0, lat_period = 0, last_lat_cyc = 0;
    int lat_run = 0, last_lat_len = 0, stb_run = 0, last_stb_len = 0, do_high_cnt = 0, fd_cnt = 0;
    logic [7:0] shreg = '0;
    logic [7:0] lat_rows [2];
    logic       prev_clk = 1'b0, prev_lat = 1'b0;

    // Display-chain model: shift on CLKimpr rise, capture on LAT rise.
    always @(negedge CLK) begin
        cyc      <= cyc + 1;
        prev_clk <= CLKimpr;
        prev_lat <= LAT;
        if (RST) begin
            rises <= 0;
            shreg <= '0;
        end else if (CLKimpr && !prev_clk) begin
            shreg <= {shreg[6:0], DO};
            rises <= rises + 1;
        end
        if (LAT && !prev_lat) begin
            lat_rows[ROW] <= shreg;
            last_rises    <= rises;
            rises         <= 0;
            lat_count     <= lat_count + 1;
            lat_period    <= cyc - last_lat_cyc;
            last_lat_cyc  <= cyc;
        end
        if (LAT) lat_run <= lat_run + 1;
        else begin
            if (lat_run != 0) last_lat_len <= lat_run;
            lat_run <= 0;
        end
        if (STB) stb_run <= stb_run + 1;
        else begin
            if (stb_run != 0) last_stb_len <= stb_run;
            stb_run <= 0;
        end
        if (DO) do_high_cnt <= do_high_cnt + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_lat(input int n);
        int target;
        int budget;
        target = lat_count + n;
        budget = n * 44 + 60;
        while (lat_count < target && budget > 0) begin
            tick();
            budget--;
        end
        if (lat_count < target) begin
            checks++;
            errors++;
            $display("FAIL wait_lat timeout: latches %0d required %0d", lat_count, target);
        end
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_DO"}, {31'd0, DO}, 0);
        check({tag, "_CLKimpr"}, {31'd0, CLKimpr}, 0);
        check({tag, "_LAT"}, {31'd0, LAT}, 0);
        check({tag, "_STB"}, {31'd0, STB}, 0);
        check({tag, "_ROW"}, {31'd0, ROW}, 0);
        check({tag, "_frame_done"}, {31'd0, frame_done}, 0);
    endtask

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] exp0;
        logic [7:0] exp1;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int fd0;
        int do0;
        logic [7:0] v;

        vecs[0] = '{b0: 8'hA5, b1: 8'h3C, exp0: 8'hA5, exp1: 8'h3C};
        vecs[1] = '{b0: 8'hFF, b1: 8'h00, exp0: 8'hFF, exp1: 8'h00};
        vecs[2] = '{b0: 8'h81, b1: 8'h7E, exp0: 8'h81, exp1: 8'h7E};
        vecs[3] = '{b0: 8'h01, b1: 8'h80, exp0: 8'h01, exp1: 8'h80};

        // Reset with no traffic: blank scan timing.
        repeat (3) tick();
        check_outputs_reset("t1_reset");
        RST = 1'b0;
        do0 = do_high_cnt;
        for (int i = 0; i < 3; i++) begin
            wait_lat(1);
            check($sformatf("t1_row_seq%0d", i), {31'd0, ROW}, i % 2);
            check($sformatf("t1_rises%0d", i), last_rises, 8);
            if (i > 0) check($sformatf("t1_period%0d", i), lat_period, 44);
        end
        repeat (20) tick();
        check("t1_lat_len", last_lat_len, 2);
        check("t1_stb_len", last_stb_len, 10);
        check("t1_do_blank", do_high_cnt - do0, 0);

        // Table of back-to-back two-byte frames.
        for (int i = 0; i < 4; i++) begin
            fd0 = fd_cnt;
            send_byte(vecs[i].b0);
            send_byte(vecs[i].b1);
            check($sformatf("vec%0d_done_pulse", i), {31'd0, frame_done}, 1);
            tick();
            check($sformatf("vec%0d_done_clear", i), {31'd0, frame_done}, 0);
            check($sformatf("vec%0d_done_count", i), fd_cnt - fd0, 1);
            wait_lat(4);
            check($sformatf("vec%0d_row0", i), {24'd0, lat_rows[0]}, {24'd0, vecs[i].exp0});
            check($sformatf("vec%0d_row1", i), {24'd0, lat_rows[1]}, {24'd0, vecs[i].exp1});
            check($sformatf("vec%0d_rises", i), last_rises, 8);
        end

        // Idle gap discards a partial frame.
        send_byte(8'hFF);
        repeat (150) tick();
        fd0 = fd_cnt;
        send_byte(8'h00);
        repeat (5) tick();
        check("t3_no_done_partial", fd_cnt - fd0, 0);
        send_byte(8'h81);
        check("t3_done_pulse", {31'd0, frame_done}, 1);
        wait_lat(4);
        check("t3_row0", {24'd0, lat_rows[0]}, 32'h00);
        check("t3_row1", {24'd0, lat_rows[1]}, 32'h81);

        // Two frames before one swap: the later one wins, no torn display.
        for (int k = 0; k < 3 && !(lat_count > 0 && ROW == 1'b0 && LAT); k++) wait_lat(1);
        check("t4_sync_row0", {31'd0, ROW}, 0);
        fd0 = fd_cnt;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        tick();
        check("t4_two_done", fd_cnt - fd0, 2);
        for (int i = 0; i < 4; i++) begin
            wait_lat(1);
            v = lat_rows[ROW];
            check($sformatf("t4_no_tear%0d", i), {31'd0, (v == 8'h11) || (v == 8'h22)}, 0);
        end
        check("t4_row0", {24'd0, lat_rows[0]}, 32'h33);
        check("t4_row1", {24'd0, lat_rows[1]}, 32'h44);

        // Frame completing on the exact row-1 SHOW exit cycle.
        for (int k = 0; k < 100 && !(LAT && ROW == 1'b1); k++) tick();
        check("t5_sync_lat_row1", {31'd0, LAT && ROW == 1'b1}, 1);
        for (int k = 0; k < 5 && !STB; k++) tick();
        check("t5_sync_stb", {31'd0, STB}, 1);
        repeat (8) tick();
        send_byte(8'h5A);
        check("t5_stb_last_cycle", {31'd0, STB}, 1);
        send_byte(8'hC3);
        check("t5_stb_exited", {31'd0, STB}, 0);
        check("t5_done_pulse", {31'd0, frame_done}, 1);
        wait_lat(2);
        check("t5_old_row0", {24'd0, lat_rows[0]}, 32'h33);
        check("t5_old_row1", {24'd0, lat_rows[1]}, 32'h44);
        wait_lat(2);
        check("t5_new_row0", {24'd0, lat_rows[0]}, 32'h5A);
        check("t5_new_row1", {24'd0, lat_rows[1]}, 32'hC3);

        // Reset mid-shift (bit 3), then mid-SHOW of row 1.
        send_byte(8'hEE);
        for (int k = 0; k < 60 && !STB; k++) tick();
        for (int k = 0; k < 20 && STB; k++) tick();
        check("t6_sync_shift", {31'd0, STB}, 0);
        repeat (13) tick();
        RST = 1'b1;
        tick();
        check_outputs_reset("t6_rst_shift");
        RST = 1'b0;
        do0 = do_high_cnt;
        wait_lat(2);
        check("t6_do_blank", do_high_cnt - do0, 0);
        for (int k = 0; k < 100 && !(LAT && ROW == 1'b1); k++) tick();
        for (int k = 0; k < 5 && !STB; k++) tick();
        check("t6_sync_show_row1", {31'd0, STB && ROW == 1'b1}, 1);
        repeat (3) tick();
        RST = 1'b1;
        tick();
        check_outputs_reset("t6_rst_show");
        RST = 1'b0;
        send_byte(8'h24);
        send_byte(8'h42);
        check("t6_done_after_restart", {31'd0, frame_done}, 1);
        wait_lat(4);
        check("t6_row0", {24'd0, lat_rows[0]}, 32'h24);
        check("t6_row1", {24'd0, lat_rows[1]}, 32'h42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d required completion", checks);
        $fatal(1, "watchdog");
    end

endmodule
